alu_pipe_acc: RTL and testbench
===============================

// Module: alu_pipe_acc
// PURPOSE
//  Parametrised, registered successor to the team's 8-op combinational ALU. Width is generic and four shift/pass ops are added.
//  Results and status flags (Z/N/C/V) are registered behind a valid/ready handshake, and an internal accumulator can replace operand a.
//  Sits between an operand source (sequencer/regfile) and a result consumer with backpressure.
// PARAMETERS
//  WIDTH    32  operand/result width, >= 4
//  SHW      $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
//  ACC_INIT 0   accumulator value after reset and after acc_clr
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready
//  sel        in   4      opcode (see BEHAVIOUR)
//  use_acc    in   1      1: operand a := accumulator; input a ignored
//  a          in   WIDTH  operand a
//  b          in   WIDTH  operand b (shift amount = b[SHW-1:0])
//  acc_clr    in   1      synchronous accumulator clear, independent of handshake
//  out_valid  out  1      result held
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out        out  WIDTH  result
//  flags      out  4      {Z,N,C,V} for out
//  acc        out  WIDTH  current accumulator value
// BEHAVIOUR
//  Opcodes (0-7 keep legacy encoding):
//  - 0 ~a; 1 a&b; 2 a^b; 3 a|b; 4 a-1; 5 a+b; 6 a-b; 7 a+1
//  - 8 a<<sh; 9 a>>sh (logical); 10 a>>>sh (arithmetic); 11 pass b; 12-15 reserved: out=0, flags Z=1 only.
//  Arithmetic: compute in WIDTH+1 bits; result truncated to WIDTH.
//  - C = carry-out for add/inc; borrow for sub/dec (C=1 iff a<b unsigned; dec: iff a==0).
//  - V = signed overflow for 4-7; C=V=0 for all other ops.
//  - Z = (out==0); N = out[WIDTH-1], for every op.
//  Pipeline: single output register, latency 1; out/flags valid the cycle after acceptance.
//  - in_ready = !out_valid | out_ready (combinational). No bubble at full throughput.
//  - out, flags and out_valid are held stable while out_valid & !out_ready.
//  - Accept with no output transfer: out_valid<=1. Output transfer with no accept: out_valid<=0. Both: out_valid stays 1, new data loaded.
//  Accumulator:
//  - On each accepted op with use_acc=1, acc <= result at the same edge as out. Back-to-back acc ops therefore chain with no stall.
//  - Ops with use_acc=0 never modify acc.
//  - acc_clr=1 forces acc <= ACC_INIT. If it coincides with an accepted use_acc op, the operand is ACC_INIT and acc <= result (op wins the write, clear supplies the operand).
//  Reset (async assert, sync-safe release): out_valid=0, out=0, flags=0, acc=ACC_INIT.
//  - An in-flight result is dropped with no output transfer.
//  - in_ready=1 immediately after deassertion.
//  Inputs are don't-care when in_valid=0; sel/a/b are sampled only on acceptance.
// STRUCTURE
//  Shared package alu_pkg:
//  - opcode localparams OP_NOT..OP_PASSB
//  - flag bit indices FLG_Z/N/C/V
//  Combinational sub-module alu_core #(WIDTH): sel, a, b -> result, flags (pure function, reusable).
//  Top holds the handshake, output register and accumulator. Estimated 150-250 RTL lines total.
// TESTING (WIDTH=32, out_ready=1 unless stated)
//  1. sel=0, a=12345678, b=87654321 -> next cycle out=EDCBA987, flags N=1; sweep sel 1-7: 02244220, 95511559, 97755779, 12345677, 99999999, 8ACF1357 (C=1), 12345679.
//  2. add FFFFFFFF+00000001 -> out=0, Z=1, C=1, V=0; add 7FFFFFFF+1 -> 80000000, N=1, V=1, C=0.
//  3. sub 80000000-1 -> 7FFFFFFF, V=1, C=0; dec a=0 -> FFFFFFFF, C=1, N=1.
//  4. Shifts:
//   - sel=10, a=80000000, b=4 -> F8000000.
//   - sel=9, same operands -> 08000000.
//   - sel=8, a=1, b=31 -> 80000000.
//   - b=0x25 uses sh=5.
//  5. Backpressure:
//   - hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out/flags unchanged, acc unchanged.
//   - Release -> 2 transfers on consecutive cycles, no loss or duplication.
//  6. Accumulator:
//   - acc_clr, then 3 back-to-back use_acc sel=7 -> out 1,2,3, acc=3.
//   - acc_clr coincident with use_acc sel=5, b=5 -> out=5, acc=5.
//  7. Reset mid-operation: assert rst_n=0 while out_valid=1 & out_ready=0 -> out_valid, out, flags = 0 without waiting for clk; acc=ACC_INIT.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the registered ALU family.
//   - Opcode encodings. Codes 0-7 keep the legacy combinational ALU encoding.
//     Codes 12-15 are reserved; they produce a zero result.
//   - Bit positions inside the 4-bit {Z,N,C,V} status vector.
//   - Small helpers that classify opcodes.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] opcode_t;

    // Legacy opcodes.
    localparam opcode_t OP_NOT   = 4'd0;
    localparam opcode_t OP_AND   = 4'd1;
    localparam opcode_t OP_XOR   = 4'd2;
    localparam opcode_t OP_OR    = 4'd3;
    localparam opcode_t OP_DEC   = 4'd4;
    localparam opcode_t OP_ADD   = 4'd5;
    localparam opcode_t OP_SUB   = 4'd6;
    localparam opcode_t OP_INC   = 4'd7;

    // Shift and pass opcodes.
    localparam opcode_t OP_SHL   = 4'd8;
    localparam opcode_t OP_SHR   = 4'd9;
    localparam opcode_t OP_SRA   = 4'd10;
    localparam opcode_t OP_PASSB = 4'd11;

    // Bit positions inside flags = {Z,N,C,V}.
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Opcodes that use the WIDTH+1 adder. They are the only ones that
    // produce C and V.
    function automatic logic is_arith(input opcode_t op);
        return (op == OP_DEC) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
    endfunction

    // Opcodes that subtract. Bit WIDTH of the difference is then a borrow.
    function automatic logic is_subtract(input opcode_t op);
        return (op == OP_SUB) || (op == OP_DEC);
    endfunction

    // Opcodes whose second operand is the constant 1.
    function automatic logic is_unit_step(input opcode_t op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Pure combinational ALU function with no state. It can be reused in any
// datapath.
//   sel    in  4      opcode (alu_pkg::OP_*)
//   a      in  WIDTH  operand a
//   b      in  WIDTH  operand b; shift amount = b[SHW-1:0]
//   result out WIDTH  result, truncated to WIDTH
//   flags  out 4      {Z,N,C,V} for result
// C carries the carry-out for add/inc and the borrow for sub/dec.
// V is signed overflow for opcodes 4-7. C and V are zero for every other op.
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] arith_b;
    logic [WIDTH:0]   sum;
    logic             ovf_add;
    logic             ovf_sub;
    logic             carry;
    logic             ovf;

    assign sh = b[SHW-1:0];

    // All four arithmetic ops share one adder/subtractor. inc and dec feed
    // the constant 1 as the second operand.
    assign arith_b = is_unit_step(sel) ? ONE : b;
    assign sum     = is_subtract(sel) ? ({1'b0, a} - {1'b0, arith_b})
                                      : ({1'b0, a} + {1'b0, arith_b});

    // Add overflows when both operands have the same sign and the sum's sign
    // differs from it. Subtract overflows when the operand signs differ and
    // the result's sign differs from a's sign.
    assign ovf_add = (a[MSB] == arith_b[MSB]) && (sum[MSB] != a[MSB]);
    assign ovf_sub = (a[MSB] != arith_b[MSB]) && (sum[MSB] != a[MSB]);

    // NOTE: every variable driven here gets a default before the case, so no
    // path through the block can infer a latch.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (sel)
            OP_NOT:   result = ~a;
            OP_AND:   result = a & b;
            OP_XOR:   result = a ^ b;
            OP_OR:    result = a | b;
            OP_DEC,
            OP_ADD,
            OP_SUB,
            OP_INC: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = is_subtract(sel) ? ovf_sub : ovf_add;
            end
            OP_SHL:   result = a << sh;
            OP_SHR:   result = a >> sh;
            OP_SRA:   result = $signed(a) >>> sh;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags        = 4'b0000;
        flags[FLG_Z] = (result == '0);
        flags[FLG_N] = result[MSB];
        flags[FLG_C] = carry;
        flags[FLG_V] = ovf;
    end

endmodule : alu_core

// File: rtl/alu_pipe_acc.sv
// -----------------------------------------------------------------------------
// alu_pipe_acc
// Registered ALU with a valid/ready handshake on each side. It also has an
// internal accumulator that can replace operand a.
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      operation presented
//   in_ready  out  1      block can accept (combinational)
//   sel       in   4      opcode
//   use_acc   in   1      operand a := accumulator
//   a, b      in   WIDTH  operands
//   acc_clr   in   1      synchronous accumulator clear, independent of handshake
//   out_valid out  1      result held in the output register
//   out_ready in   1      consumer accepts
//   out       out  WIDTH  result
//   flags     out  4      {Z,N,C,V} for out
//   acc       out  WIDTH  current accumulator value
// The single output register gives a latency of 1. The register reloads in
// the same cycle it drains, so full throughput has no bubble.
// -----------------------------------------------------------------------------
module alu_pipe_acc
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc
);

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    // The output register can take new data when it is empty or when it is
    // being drained in this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear that coincides with an accumulator op supplies ACC_INIT as the
    // operand. The op then writes its own result into acc.
    assign op_a = !use_acc ? a : (acc_clr ? ACC_INIT : acc);

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel    (sel),
        .a      (op_a),
        .b      (b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // NOTE: state registers use non-blocking assignments, so every register
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= alu_result;
            flags     <= alu_flags;
        end else if (out_ready) begin
            // Drain with nothing new to load. Data is left as is, because it
            // is meaningless once out_valid drops.
            out_valid <= 1'b0;
        end
    end

    // The accumulator updates on the same edge as out. A chain of
    // back-to-back accumulator ops therefore sees each previous result with
    // no stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= ACC_INIT;
        end else if (accept && use_acc) begin
            acc <= alu_result;
        end else if (acc_clr) begin
            acc <= ACC_INIT;
        end
    end

endmodule : alu_pipe_acc

// File: tb/tb_alu_pipe_acc.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_acc
// Directed bench for alu_pipe_acc at WIDTH=32.
//   - A scoreboard model runs every falling edge. It keeps a queue of
//     results that were accepted but not yet transferred, and its own
//     accumulator. It computes each result from plain wide arithmetic.
//   - The driver changes inputs 1 time unit after the rising edge. It also
//     checks hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_alu_pipe_acc;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [3:0]   flg;
        logic [W-1:0] res;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   sel;
    logic         use_acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;
    logic [W-1:0] acc;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t         exp_q[$];
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] xfer_vals[$];
    int           xfer_cyc[$];

    alu_pipe_acc #(
        .WIDTH    (W),
        .ACC_INIT ('0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference ALU. It uses unsigned and signed 64-bit arithmetic on the
    // operands directly.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        longint       sx;
        longint       sy;
        longint       sr;
        longint       ux;
        longint       uy;
        int           sh;
        r  = '0;
        c  = 1'b0;
        v  = 1'b0;
        sr = 0;
        sh = int'(y[4:0]);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (op)
            4'd0:  r = ~x;
            4'd1:  r = x & y;
            4'd2:  r = x ^ y;
            4'd3:  r = x | y;
            4'd4:  begin r = x - 1; c = (x == 0); sr = sx - 1; end
            4'd5:  begin r = x + y; c = (ux + uy) > 64'sd4294967295; sr = sx + sy; end
            4'd6:  begin r = x - y; c = (ux < uy); sr = sx - sy; end
            4'd7:  begin r = x + 1; c = (x == 32'hFFFF_FFFF); sr = sx + 1; end
            4'd8:  r = x << sh;
            4'd9:  r = x >> sh;
            4'd10: r = (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd11: r = y;
            default: r = '0;
        endcase
        if (op >= 4'd4 && op <= 4'd7)
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.res = r;
        e.flg = {(r == 0), r[31], c, v};
        return e;
    endfunction

    // Scoreboard. It checks DUT state against the model and then advances
    // the model by the handshake that the next rising edge will complete.
    always @(negedge clk) begin
        logic         exp_in_ready;
        logic [W-1:0] opa;
        exp_t         e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            m_acc = '0;
            check("rst_out_valid", 64'(out_valid), 64'(1'b0));
            check("rst_out_flags", {28'd0, flags, out}, 64'd0);
            check("rst_acc", 64'(acc), 64'd0);
        end else begin
            exp_in_ready = (exp_q.size() == 0) || out_ready;
            check("mon_in_ready", 64'(in_ready), 64'(exp_in_ready));
            check("mon_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check("mon_out_data", 64'({flags, out}), 64'(exp_q[0]));
            check("mon_acc", 64'(acc), 64'(m_acc));
            if (out_valid && out_ready) begin
                xfer_vals.push_back(out);
                xfer_cyc.push_back(cyc);
            end
            if (exp_q.size() != 0 && out_ready)
                exp_q.delete(0);
            if (in_valid && exp_in_ready) begin
                opa = use_acc ? (acc_clr ? '0 : m_acc) : a;
                e = model(sel, opa, b);
                exp_q.push_back(e);
                if (use_acc) m_acc = e.res;
                else if (acc_clr) m_acc = '0;
            end else if (acc_clr) begin
                m_acc = '0;
            end
        end
    end

    task automatic issue(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ua, input logic clr);
        in_valid = 1'b1;
        sel      = s;
        a        = x;
        b        = y;
        use_acc  = ua;
        acc_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        use_acc  = 1'b0;
        acc_clr  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] eo, input logic [3:0] ef);
        check(name, 64'({flags, out}), 64'({ef, eo}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] t1_out[8];
        logic [3:0]   t1_flg[8];
        exp_t         pin;
        int           n0;

        t1_out = '{32'hEDCBA987, 32'h02244220, 32'h95511559, 32'h97755779,
                   32'h12345677, 32'h99999999, 32'h8ACF1357, 32'h12345679};
        t1_flg = '{4'b0100, 4'b0000, 4'b0100, 4'b0100,
                   4'b0000, 4'b0100, 4'b0111, 4'b0000};

        in_valid  = 1'b0;
        sel       = '0;
        a         = '0;
        b         = '0;
        use_acc   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("in_ready_after_reset", 64'(in_ready), 64'(1'b1));

        // Pin the model against hand-computed values.
        pin = model(4'd6, 32'h12345678, 32'h87654321);
        check("pin_model_sub", 64'(pin), 64'({4'b0111, 32'h8ACF1357}));
        pin = model(4'd10, 32'h80000000, 32'h4);
        check("pin_model_sra", 64'(pin), 64'({4'b0100, 32'hF8000000}));
        pin = model(4'd5, 32'h7FFFFFFF, 32'h1);
        check("pin_model_addv", 64'(pin), 64'({4'b0101, 32'h80000000}));

        // 1: legacy opcode sweep, back to back.
        for (int i = 0; i < 8; i++) begin
            issue(4'(i), 32'h12345678, 32'h87654321, 1'b0, 1'b0);
            chk_out($sformatf("t1_sel%0d", i), t1_out[i], t1_flg[i]);
        end

        // 2/3: carry, borrow and overflow corners.
        issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
        chk_out("t2_add_wrap", 32'h0, 4'b1010);
        issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
        chk_out("t2_add_ovf", 32'h80000000, 4'b0101);
        issue(OP_SUB, 32'h80000000, 32'h1, 1'b0, 1'b0);
        chk_out("t3_sub_ovf", 32'h7FFFFFFF, 4'b0001);
        issue(OP_DEC, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_out("t3_dec_zero", 32'hFFFFFFFF, 4'b0110);

        // 4: shifts, pass-through and reserved codes.
        issue(OP_SRA, 32'h80000000, 32'h4, 1'b0, 1'b0);
        chk_out("t4_sra", 32'hF8000000, 4'b0100);
        issue(OP_SHR, 32'h80000000, 32'h4, 1'b0, 1'b0);
        chk_out("t4_shr", 32'h08000000, 4'b0000);
        issue(OP_SHL, 32'h1, 32'd31, 1'b0, 1'b0);
        chk_out("t4_shl31", 32'h80000000, 4'b0100);
        issue(OP_SHL, 32'h1, 32'h25, 1'b0, 1'b0);
        chk_out("t4_shamt_mask", 32'h20, 4'b0000);
        issue(OP_PASSB, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        chk_out("t4_passb_zero", 32'h0, 4'b1000);
        issue(4'd12, 32'h5, 32'h5, 1'b0, 1'b0);
        chk_out("t4_reserved12", 32'h0, 4'b1000);
        issue(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk_out("t4_reserved15", 32'h0, 4'b1000);
        idle();

        // 5: backpressure. Hold one result and stall the next op.
        out_ready = 1'b0;
        issue(OP_PASSB, 32'h0, 32'hAAAA0001, 1'b0, 1'b0);
        n0 = xfer_vals.size();
        in_valid = 1'b1;
        sel      = OP_INC;
        use_acc  = 1'b1;
        b        = '0;
        for (int i = 0; i < 3; i++) begin
            check("t5_in_ready_low", 64'(in_ready), 64'(1'b0));
            chk_out("t5_held", 32'hAAAA0001, 4'b0100);
            check("t5_acc_held", 64'(acc), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_out("t5_second", 32'h1, 4'b0000);
        idle();
        check("t5_xfer_count", 64'(xfer_vals.size() - n0), 64'd2);
        if (xfer_vals.size() >= n0 + 2) begin
            check("t5_xfer0", 64'(xfer_vals[n0]), 64'(32'hAAAA0001));
            check("t5_xfer1", 64'(xfer_vals[n0+1]), 64'(32'h1));
            check("t5_xfer_consec", 64'(xfer_cyc[n0+1] - xfer_cyc[n0]), 64'd1);
        end

        // 6: accumulator chain, then a clear that coincides with an acc op.
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check("t6_acc_cleared", 64'(acc), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            issue(OP_INC, 32'hDEAD0000, 32'h0, 1'b1, 1'b0);
            chk_out($sformatf("t6_chain%0d", i), 32'(i), 4'b0000);
        end
        check("t6_acc3", 64'(acc), 64'd3);
        issue(OP_ADD, 32'h0, 32'h5, 1'b1, 1'b1);
        chk_out("t6_clr_op", 32'h5, 4'b0000);
        check("t6_clr_op_acc", 64'(acc), 64'd5);
        idle();

        // 7: asynchronous reset while a result is stalled.
        out_ready = 1'b0;
        issue(OP_PASSB, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk_out("t7_before_reset", 32'hDEADBEEF, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_valid", 64'(out_valid), 64'(1'b0));
        chk_out("t7_async_out", 32'h0, 4'b0000);
        check("t7_async_acc", 64'(acc), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check("t7_in_ready_release", 64'(in_ready), 64'(1'b1));
        issue(OP_ADD, 32'h3, 32'h4, 1'b0, 1'b0);
        chk_out("t7_after_reset_op", 32'h7, 4'b0000);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_pipe_acc
